// File: rtl/mau_host_driver.sv
// rtl/mau_host_driver.sv - host-side command driver for the MAU byte-wide host interface
// Optional watchdog on the busy waits: define MAU_DRV_TIMEOUT_EN.
module mau_host_driver #(
  parameter int MATRIX_DIM   = 8,
  parameter int RD_LAT       = 2,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_a,
  input  logic [1:0] cmd_d,
  input  logic [1:0] cmd_func,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic [7:0] src_data,
  output logic       snk_valid,
  input  logic       snk_ready,
  output logic [7:0] snk_data,
  output logic [7:0] host_instruction,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  input  logic       busy_flag,
  output logic       done,
  output logic       err
);

  localparam int N  = MATRIX_DIM * MATRIX_DIM;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [PW-1:0] PTR0     = '0;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FILL      = 4'd1;
  localparam logic [3:0] S_WAIT_IDLE = 4'd2;
  localparam logic [3:0] S_ISSUE     = 4'd3;
  localparam logic [3:0] S_STREAM    = 4'd4;
  localparam logic [3:0] S_CAPT_WAIT = 4'd5;
  localparam logic [3:0] S_CAPTURE   = 4'd6;
  localparam logic [3:0] S_DRAIN     = 4'd7;
  localparam logic [3:0] S_EXEC_WAIT = 4'd8;
  localparam logic [3:0] S_FINISH    = 4'd9;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_STORE   = 2'b10;
  localparam logic [1:0] OP_COMPUTE = 2'b11;

  logic [3:0]    state, state_n;
  logic [1:0]    op_q;
  logic [7:0]    instr_q;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [7:0]    data_in_q;
  logic          seen_busy;
  logic          tmo_hit;
  logic          mem_we;
  logic [7:0]    mem_wd;
  logic [7:0]    mem [N];

  assign rd_next = rd_ptr + 1'b1;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP:  state_n = S_FINISH;
            OP_LOAD: state_n = S_FILL;
            default: state_n = S_WAIT_IDLE;
          endcase
        end
      S_FILL:      if (src_valid && cnt == LAST) state_n = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (!busy_flag)   state_n = S_ISSUE;
        else if (tmo_hit) state_n = S_FINISH;
      end
      S_ISSUE: begin
        case (op_q)
          OP_LOAD:  state_n = S_STREAM;
          OP_STORE: state_n = (RD_LAT > 1) ? S_CAPT_WAIT : S_CAPTURE;
          default:  state_n = S_EXEC_WAIT;
        endcase
      end
      S_STREAM:    if (cnt == LAST) state_n = S_FINISH;
      S_CAPT_WAIT: if (cnt == LAT_LAST) state_n = S_CAPTURE;
      S_CAPTURE:   if (cnt == LAST) state_n = S_DRAIN;
      S_DRAIN:     if (snk_ready && cnt == LAST) state_n = S_FINISH;
      // COMPUTE completion needs a busy rise before the fall, so a stale low is not mistaken for done
      S_EXEC_WAIT: begin
        if (seen_busy && !busy_flag) state_n = S_FINISH;
        else if (tmo_hit)            state_n = S_FINISH;
      end
      S_FINISH:    state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  assign mem_we = (state == S_FILL && src_valid) || (state == S_CAPTURE);
  assign mem_wd = (state == S_FILL) ? src_data : data_out;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      instr_q   <= 8'h00;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_in_q <= 8'h00;
      seen_busy <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            op_q    <= cmd_op;
            instr_q <= {cmd_op, cmd_a, (cmd_op == OP_COMPUTE) ? {cmd_d, cmd_func} : 4'b0000};
            cnt     <= '0;
            wr_ptr  <= '0;
          end
        S_FILL:
          if (src_valid && cnt != LAST) begin
            cnt    <= cnt + 1'b1;
            wr_ptr <= wr_ptr + 1'b1;
          end
        S_ISSUE: begin
          cnt       <= '0;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          seen_busy <= 1'b0;
          if (op_q == OP_LOAD) data_in_q <= mem[PTR0];
        end
        // rd_ptr names the byte currently on data_in; the next one is fetched a cycle ahead
        S_STREAM:
          if (cnt != LAST) begin
            data_in_q <= mem[rd_next];
            rd_ptr    <= rd_next;
            cnt       <= cnt + 1'b1;
          end
        S_CAPT_WAIT:
          cnt <= (cnt == LAT_LAST) ? '0 : cnt + 1'b1;
        S_CAPTURE:
          if (cnt != LAST) begin
            cnt    <= cnt + 1'b1;
            wr_ptr <= wr_ptr + 1'b1;
          end else begin
            cnt    <= '0;
            rd_ptr <= '0;
          end
        S_DRAIN:
          if (snk_ready && cnt != LAST) begin
            cnt    <= cnt + 1'b1;
            rd_ptr <= rd_next;
          end
        S_EXEC_WAIT:
          if (busy_flag) seen_busy <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MAU_DRV_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Fires only while the wait is still blocked, so a normal exit on the last cycle wins
  assign tmo_hit = (tmo_cnt == TMO_LAST) &&
                   ((state == S_WAIT_IDLE && busy_flag) ||
                    (state == S_EXEC_WAIT && !(seen_busy && !busy_flag)));
  assign err = (state == S_FINISH) && err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_n != state)
        tmo_cnt <= '0;
      else if (state == S_WAIT_IDLE || state == S_EXEC_WAIT)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_IDLE)
        err_q <= 1'b0;
      else if (tmo_hit)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^BUSY_TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign err            = 1'b0;
`endif

  assign cmd_ready        = (state == S_IDLE);
  assign src_ready        = (state == S_FILL);
  assign snk_valid        = (state == S_DRAIN);
  assign snk_data         = snk_valid ? mem[rd_ptr] : 8'h00;
  assign host_instruction = (state == S_ISSUE) ? instr_q : 8'h00;
  assign data_in          = data_in_q;
  assign done             = (state == S_FINISH);

endmodule

// File: tb/tb_mau_host_driver.sv
// tb/tb_mau_host_driver.sv - self-checking bench for mau_host_driver
module tb_mau_host_driver;
  localparam int DIM = 8;
  localparam int N   = DIM * DIM;
  localparam int RDL = 2;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op, cmd_a, cmd_d, cmd_func;
  logic       src_valid, src_ready;
  logic [7:0] src_data;
  logic       snk_valid, snk_ready;
  logic [7:0] snk_data;
  logic [7:0] host_instruction, data_in, data_out;
  logic       busy_flag, done, err;

  always #5 clk = ~clk;

  mau_host_driver #(.MATRIX_DIM(DIM), .RD_LAT(RDL), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a),
    .cmd_d(cmd_d), .cmd_func(cmd_func),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .host_instruction(host_instruction), .data_in(data_in), .data_out(data_out),
    .busy_flag(busy_flag), .done(done), .err(err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model state
  bit         chk_en = 0;
  logic       pending = 1'b0;
  logic [1:0] pend_op = 2'b00;
  int         exp_instr = 0, accept_cyc = 0, issue_cyc = 0, issue_count = 0;
  int         stream_k = 0, pop_idx = 0, done_cnt = 0, done_cyc = 0;
  int         obs_instr = 0, first_pop = 0, last_pop = 0, store_issue = -1000;
  logic       exp_err = 1'b0, done_err = 1'b0;
  logic       prev_busy = 1'b0, prev_sv = 1'b0, prev_sr = 1'b0;
  logic [7:0] prev_sd = 8'h00;
  int         load_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      pending = 1'b0;
      issue_count = 0;
      prev_sv = 1'b0;
      store_issue = -1000;
    end else if (chk_en) begin
      check("cmd_ready", cmd_ready, !pending);
      if (host_instruction != 8'h00) begin
        check("issue_once", issue_count, 0);
        check("instr", host_instruction, pending ? exp_instr : 0);
        check("issue_after_idle", prev_busy, 0);
        issue_cyc = cyc;
        issue_count++;
        obs_instr = host_instruction;
        if (host_instruction[7:6] == 2'b10) store_issue = cyc;
      end
      if (pending && pend_op == 2'b01 && issue_count == 1 && cyc > issue_cyc &&
          cyc <= issue_cyc + N && (cyc - issue_cyc - 1) < load_q.size()) begin
        check("data_in", data_in, load_q[cyc-issue_cyc-1]);
        stream_k = cyc - issue_cyc;
      end
      if (prev_sv && !prev_sr) begin
        check("snk_hold_valid", snk_valid, 1);
        check("snk_hold_data", snk_data, prev_sd);
      end
      if (snk_valid && snk_ready) begin
        check("snk_data", snk_data, (8'hA0 + pop_idx) & 8'hFF);
        if (pop_idx == 0) first_pop = snk_data;
        last_pop = snk_data;
        pop_idx++;
      end
      if (done) begin
        check("done_pending", pending, 1);
        check("err", err, exp_err);
        if (pend_op == 2'b01 && !exp_err) check("load_len", stream_k, N);
        if (pend_op == 2'b10 && !exp_err) check("store_len", pop_idx, N);
        if (pend_op == 2'b00) check("nop_latency", cyc - accept_cyc, 1);
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
        pending = 1'b0;
      end else begin
        check("err_idle", err, 0);
      end
      if (cmd_valid && cmd_ready) begin
        pending = 1'b1;
        pend_op = cmd_op;
        exp_instr = cmd_op * 64 + cmd_a * 16 + ((cmd_op == 2'b11) ? cmd_d * 4 + cmd_func : 0);
        accept_cyc = cyc;
        issue_count = 0;
        stream_k = 0;
        pop_idx = 0;
      end
      prev_busy = busy_flag;
      prev_sv = snk_valid;
      prev_sr = snk_ready;
      prev_sd = snk_data;
    end
  end

  // MAU read side: byte k appears RD_LAT+k cycles after a STORE instruction
  initial begin
    int k;
    data_out = 8'h5A;
    forever begin
      @(posedge clk);
      #1;
      k = cyc - store_issue - RDL;
      data_out = (k >= 0 && k < N) ? 8'((8'hA0 + k) & 8'hFF) : 8'h5A;
    end
  end

  task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [1:0] d,
                      input logic [1:0] f);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    load_q.delete();
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_d = d;
    cmd_func = f;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
  endtask

  task automatic fill(input int base, input bit gap);
    int n;
    for (int k = 0; k < N; k++) begin
      if (gap && k == 10) begin
        src_valid = 1'b0;
        tick();
      end
      src_valid = 1'b1;
      src_data = 8'((base + k) & 8'hFF);
      n = 0;
      @(negedge clk);
      while (!src_ready && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (!src_ready) begin
        check("fill_stall", 0, 1);
        src_valid = 1'b0;
        return;
      end
      load_q.push_back(src_data);
      tick();
    end
    src_valid = 1'b1;
    src_data = 8'hFF;
    @(negedge clk);
    check("src_ready_after_full", src_ready, 0);
    tick();
    src_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int start = done_cnt;
    for (int n = 0; n < budget && done_cnt == start; n++) begin
      snk_ready = toggle ? ~snk_ready : 1'b1;
      tick();
    end
    check("done_seen", done_cnt != start, 1);
  endtask

  task automatic wait_issue(input int budget);
    for (int n = 0; n < budget && issue_count == 0; n++) tick();
    check("issue_seen", issue_count, 1);
  endtask

  initial begin
    int fall;
    int n;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 2'b00; cmd_d = 2'b00; cmd_func = 2'b00;
    src_valid = 1'b0; src_data = 8'h00; snk_ready = 1'b0; busy_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_src_ready", src_ready, 0);
    check("rst_snk_valid", snk_valid, 0);
    check("rst_snk_data", snk_data, 0);
    check("rst_instr", host_instruction, 0);
    check("rst_data_in", data_in, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    chk_en = 1;
    tick();

    send(2'b00, 2'b01, 2'b00, 2'b00);
    wait_done(10, 0);

    send(2'b01, 2'b10, 2'b00, 2'b00);
    fill(0, 1);
    wait_done(200, 0);
    check("load_instr", obs_instr, 'h60);
    check("load_done_lat", done_cyc - issue_cyc, N + 1);
    check("load_data_hold", data_in, 'h3F);

    snk_ready = 1'b0;
    send(2'b10, 2'b01, 2'b00, 2'b00);
    wait_done(400, 1);
    check("store_instr", obs_instr, 'h90);
    check("store_first", first_pop, 'hA0);
    check("store_last", last_pop, 'hDF);
    check("store_err", done_err, 0);

    send(2'b11, 2'b00, 2'b11, 2'b11);
    wait_issue(20);
    busy_flag = 1'b1;
    repeat (10) tick();
    busy_flag = 1'b0;
    fall = cyc;
    wait_done(50, 0);
    check("cmp_instr", obs_instr, 'hCF);
    check("cmp_done_lat", done_cyc - fall, 1);

    busy_flag = 1'b1;
    send(2'b01, 2'b00, 2'b00, 2'b00);
    fill('h80, 0);
    repeat (5) tick();
    check("no_early_issue", issue_count, 0);
    busy_flag = 1'b0;
    fall = cyc;
    wait_done(200, 0);
    check("busy_issue_lat", issue_cyc - fall, 1);
    check("busy_load_instr", obs_instr, 'h40);

    send(2'b01, 2'b11, 2'b00, 2'b00);
    fill('h10, 0);
    n = 0;
    while (!(issue_count == 1 && cyc == issue_cyc + 21) && n < 300) begin
      tick();
      n++;
    end
    check("mid_stream_byte20", data_in, 'h24);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_instr", host_instruction, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_done", done, 0);
    snk_ready = 1'b1;
    send(2'b10, 2'b11, 2'b00, 2'b00);
    wait_done(300, 0);
    check("store2_instr", obs_instr, 'hB0);
    check("store2_first", first_pop, 'hA0);
    check("store2_last", last_pop, 'hDF);

`ifdef MAU_DRV_TIMEOUT_EN
    send(2'b11, 2'b01, 2'b10, 2'b00);
    wait_issue(20);
    busy_flag = 1'b1;
    exp_err = 1'b1;
    wait_done(60, 0);
    check("tmo_exec_lat", done_cyc - issue_cyc, TMO + 1);
    check("tmo_exec_err", done_err, 1);
    send(2'b11, 2'b10, 2'b01, 2'b01);
    wait_done(60, 0);
    check("tmo_wait_lat", done_cyc - accept_cyc, TMO + 1);
    check("tmo_wait_err", done_err, 1);
    check("tmo_no_issue", issue_count, 0);
    exp_err = 1'b0;
    busy_flag = 1'b0;
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mau_host_driver.md
Name: mau_host_driver

Overview:
Host-side initiator for the matrix algebra unit's byte-wide host interface.
- Accepts high-level commands (LOAD matrix, STORE matrix, COMPUTE) from a local requester over a valid/ready handshake.
- Drives host_instruction and data_in into the MAU and captures data_out.
- Buffers one full matrix of MATRIX_DIM*MATRIX_DIM bytes, so LOAD streams and STORE captures run back-to-back with no stalls on the MAU side.

Parameters:
- MATRIX_DIM, 8, matrix side; N = MATRIX_DIM*MATRIX_DIM bytes per matrix.
- RD_LAT, 2, cycles from STORE instruction to first valid data_out byte.
- BUSY_TIMEOUT, 1024, watchdog limit in cycles (used only with MAU_DRV_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  driver can accept a command
- cmd_op  in  2  00 NOP, 01 LOAD, 10 STORE, 11 COMPUTE
- cmd_a  in  2  BRAM index (LOAD/STORE target; COMPUTE aa source and destination)
- cmd_d  in  2  COMPUTE dd source BRAM
- cmd_func  in  2  00 add, 01 shift, 10 sub, 11 mul
- src_valid  in  1  LOAD byte available
- src_ready  out  1  driver accepts LOAD byte
- src_data  in  8  LOAD byte, row-major
- snk_valid  out  1  STORE byte available
- snk_ready  in  1  requester accepts STORE byte
- snk_data  out  8  STORE byte, row-major
- host_instruction  out  8  to MAU
- data_in  out  8  to MAU
- data_out  in  8  from MAU
- busy_flag  in  1  from MAU
- done  out  1  one-cycle pulse when a command completes
- err  out  1  valid with done; 1 = timeout

Behaviour:
Reset (rst=0 at a clock edge):
- All outputs 0 except cmd_ready=1.
- FSM goes to IDLE; buffer pointers clear.
- Reset mid-command abandons it; no done pulse is produced.

Instruction byte encoding:
- [7:6] = cmd_op.
- LOAD/STORE: [5:4] = cmd_a, [3:0] = 0.
- COMPUTE: [5:4] = cmd_a, [3:2] = cmd_d, [1:0] = cmd_func.
- host_instruction is 8'h00 (NOP) on every cycle except the single issue cycle.

Command acceptance:
- A command is accepted on cycle cmd_valid & cmd_ready; cmd_ready=0 from then until the done cycle.
- cmd_op=NOP is accepted and completes with done=1, err=0 on the next cycle, without touching the MAU.

States: IDLE, FILL, WAIT_IDLE, ISSUE, STREAM, CAPT_WAIT, CAPTURE, DRAIN, EXEC_WAIT, FINISH.
- LOAD: IDLE→FILL
  - src_ready=1; bytes are written into the buffer on src_valid&src_ready until N bytes are held.
  - →WAIT_IDLE: hold until busy_flag=0.
  - →ISSUE: the instruction is driven for one cycle (cycle T).
  - →STREAM: byte k is driven on data_in at cycle T+1+k, k=0..N-1, with no gaps.
  - →FINISH.
- STORE: IDLE→WAIT_IDLE→ISSUE (cycle T)→CAPT_WAIT for RD_LAT-1 cycles→CAPTURE.
  - data_out is sampled at cycles T+RD_LAT .. T+RD_LAT+N-1 into the buffer.
  - →DRAIN: snk_valid=1 while the buffer is non-empty; pop on snk_valid&snk_ready; snk_data is stable while stalled.
  - →FINISH after N pops.
- COMPUTE: IDLE→WAIT_IDLE→ISSUE→EXEC_WAIT.
  - First wait for busy_flag=1, then wait for busy_flag=0.
  - →FINISH.
- FINISH: done=1 for one cycle, err per the watchdog; →IDLE with cmd_ready=1.

Buffer:
- N x 8 bits, single read pointer and single write pointer, each 0..N-1.
- Pointers clear on entry to FILL/CAPTURE and do not wrap within a command.
- FILL ignores src_valid once N bytes are held (src_ready drops the same cycle the Nth byte is taken).
- data_in holds the last streamed byte after STREAM; its value is don't-care outside STREAM.

Optional Feature:
MAU_DRV_TIMEOUT_EN
- Defined: a counter runs in WAIT_IDLE and EXEC_WAIT and clears on every state entry.
  - Reaching BUSY_TIMEOUT cycles forces FINISH with done=1, err=1.
  - On a WAIT_IDLE timeout, no instruction is issued.
- Undefined: no counter; waits are unbounded; err is tied to 0.

Test Plan:
- LOAD to BRAM2, src bytes 0x00..0x3F, busy_flag=0 → one cycle host_instruction=8'h60, then data_in 0x00..0x3F on 64 consecutive cycles, done=1, err=0.
- STORE from BRAM1, RD_LAT=2, model drives data_out=0xA0+k at T+2+k → host_instruction=8'h90 at T; snk_data sequence 0xA0..0xDF matches; snk_ready toggled 1/0 every cycle holds snk_data stable while stalled.
- COMPUTE a=0, d=3, func=mul → host_instruction=8'hCF; busy_flag high 10 cycles then low → done exactly 1 cycle after busy_flag falls.
- busy_flag=1 at LOAD start, dropped after 5 cycles → instruction issued on the first cycle after busy_flag=0, never earlier.
- rst=0 mid-STREAM at byte 20 → next cycle host_instruction=0, cmd_ready=1, done=0; a following STORE runs normally.
- With MAU_DRV_TIMEOUT_EN, BUSY_TIMEOUT=16, COMPUTE and busy_flag stuck at 1 → done=1, err=1 exactly 16 cycles after entering EXEC_WAIT.
